bird_sprite_fetch: RTL and testbench

BIRD_SPRITE_FETCH -- requirements
Module: bird_sprite_fetch

---
 rtl/bird_sprite_fetch.sv | 99 +++++++++
 tb/tb_bird_sprite_fetch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bird_sprite_fetch.sv
// Bird sprite fetch: maps the current pixel to a sprite ROM address, then
// keys out the transparent colour. The pipeline has three stages and takes one pixel per cycle.
// It also animates the wings by switching between the two sprite ROMs every
// FLAP_FRAMES video frames.
module bird_sprite_fetch #(
    parameter int          SPR_W       = 30,
    parameter int          SPR_H       = 30,
    parameter int          FLAP_FRAMES = 8,
    parameter logic [15:0] TRANSP      = 16'hF81F
) (
    input  logic        clka,
    input  logic        rsta,
    input  logic        frame_start,
    input  logic        flap_en,
    input  logic [9:0]  bird_x,
    input  logic [9:0]  bird_y,
    input  logic        pix_valid,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [9:0]  rom_addr,
    output logic        rom_sel,
    input  logic [15:0] rom_data,
    output logic        out_valid,
    output logic        out_hit,
    output logic [15:0] out_rgb
);

    localparam int          CW      = (FLAP_FRAMES > 1) ? $clog2(FLAP_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FLAP_FRAMES - 1);
    localparam logic [10:0] SPR_W11 = 11'(SPR_W);
    localparam logic [10:0] SPR_H11 = 11'(SPR_H);
    localparam logic [9:0]  SPR_W10 = 10'(SPR_W);

    logic [9:0]    bx, by;
    logic [CW-1:0] cnt;
    logic          in_box;
    logic [9:0]    addr_next;
    logic          v1, h1, v2, h2;

    // Box test uses 11-bit sums so a sprite near the right/bottom edge does not wrap
    always_comb begin
        in_box    = pix_valid
                  & ({1'b0, pix_x} >= {1'b0, bx}) & ({1'b0, pix_x} < ({1'b0, bx} + SPR_W11))
                  & ({1'b0, pix_y} >= {1'b0, by}) & ({1'b0, pix_y} < ({1'b0, by} + SPR_H11));
        addr_next = '0;
        if (in_box)
            addr_next = (pix_y - by) * SPR_W10 + (pix_x - bx);
    end

    // Sprite position latch and wing-animation frame counter, updated only at frame_start
    always_ff @(posedge clka) begin
        if (!rsta) begin
            bx      <= '0;
            by      <= '0;
            cnt     <= '0;
            rom_sel <= 1'b0;
        end else begin
            if (frame_start) begin
                bx <= bird_x;
                by <= bird_y;
            end
            if (!flap_en) begin
                cnt     <= '0;
                rom_sel <= 1'b0;
            end else if (frame_start) begin
                if (cnt == CNT_MAX) begin
                    cnt     <= '0;
                    rom_sel <= ~rom_sel;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Three-stage pixel pipeline: address, ROM read, colour key
    always_ff @(posedge clka) begin
        if (!rsta) begin
            rom_addr  <= '0;
            v1        <= 1'b0;
            h1        <= 1'b0;
            v2        <= 1'b0;
            h2        <= 1'b0;
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_rgb   <= '0;
        end else begin
            rom_addr  <= addr_next;
            v1        <= pix_valid;
            h1        <= in_box;
            v2        <= v1;
            h2        <= h1;
            out_valid <= v2;
            out_hit   <= h2 & (rom_data != TRANSP);
            out_rgb   <= (h2 && (rom_data != TRANSP)) ? rom_data : '0;
        end
    end

endmodule

// File: tb/tb_bird_sprite_fetch.sv
// Directed bench for bird_sprite_fetch with a registered-read sprite ROM model.
module tb_bird_sprite_fetch;

    logic        clk = 1'b0;
    logic        rsta;
    logic        frame_start;
    logic        flap_en;
    logic [9:0]  bird_x, bird_y;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y;
    logic [9:0]  rom_addr;
    logic        rom_sel;
    logic [15:0] rom_data;
    logic        out_valid, out_hit;
    logic [15:0] out_rgb;

    logic        ovr_en;
    logic [15:0] ovr_val;

    int errors = 0;
    int checks = 0;

    bird_sprite_fetch #(
        .SPR_W(30), .SPR_H(30), .FLAP_FRAMES(8), .TRANSP(16'hF81F)
    ) dut (
        .clka(clk), .rsta(rsta), .frame_start(frame_start), .flap_en(flap_en),
        .bird_x(bird_x), .bird_y(bird_y), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .rom_addr(rom_addr), .rom_sel(rom_sel),
        .rom_data(rom_data), .out_valid(out_valid), .out_hit(out_hit),
        .out_rgb(out_rgb)
    );

    always #5 clk = ~clk;

    // ROM model: registered read; data encodes sel and address unless overridden
    always @(posedge clk)
        rom_data <= ovr_en ? ovr_val : {5'd0, rom_sel, rom_addr};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic [9:0] x, input logic [9:0] y);
        bird_x = x;
        bird_y = y;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    // Present one pixel, check rom_addr at T+1 and outputs at T+3
    task automatic pix(input string tag, input logic vld, input logic [9:0] x, input logic [9:0] y,
                       input logic [9:0] eaddr, input logic ehit, input logic [15:0] ergb);
        pix_valid = vld;
        pix_x = x;
        pix_y = y;
        tick();
        pix_valid = 1'b0;
        chk({tag, ".addr"}, 16'(rom_addr), 16'(eaddr));
        tick();
        tick();
        chk({tag, ".valid"}, 16'(out_valid), 16'(vld));
        chk({tag, ".hit"}, 16'(out_hit), 16'(ehit));
        chk({tag, ".rgb"}, out_rgb, ergb);
    endtask

    initial begin
        rsta = 1'b0; frame_start = 1'b0; flap_en = 1'b0;
        bird_x = '0; bird_y = '0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
        ovr_en = 1'b0; ovr_val = '0;
        tick(); tick(); tick();
        chk("rst.addr", 16'(rom_addr), 16'h0);
        chk("rst.sel", 16'(rom_sel), 16'h0);
        chk("rst.valid", 16'(out_valid), 16'h0);
        chk("rst.hit", 16'(out_hit), 16'h0);
        chk("rst.rgb", out_rgb, 16'h0);
        rsta = 1'b1;
        tick();

        // Basic addressing and colour pass-through
        frame(10'd100, 10'd50);
        ovr_en = 1'b1; ovr_val = 16'h07E0;
        pix("topleft", 1'b1, 10'd100, 10'd50, 10'd0, 1'b1, 16'h07E0);
        pix("botright", 1'b1, 10'd129, 10'd79, 10'd899, 1'b1, 16'h07E0);
        ovr_en = 1'b0;
        pix("mid", 1'b1, 10'd110, 10'd51, 10'd40, 1'b1, 16'h0028);

        // Outside the box and invalid pixels
        pix("right", 1'b1, 10'd130, 10'd50, 10'd0, 1'b0, 16'h0);
        pix("left", 1'b1, 10'd99, 10'd50, 10'd0, 1'b0, 16'h0);
        pix("below", 1'b1, 10'd100, 10'd80, 10'd0, 1'b0, 16'h0);
        pix("novalid", 1'b0, 10'd105, 10'd55, 10'd0, 1'b0, 16'h0);

        // Transparent key
        ovr_en = 1'b1; ovr_val = 16'hF81F;
        pix("transp", 1'b1, 10'd105, 10'd55, 10'd155, 1'b0, 16'h0);
        ovr_en = 1'b0;

        // Position changes only take effect at frame_start
        bird_x = 10'd200;
        tick();
        pix("oldpos", 1'b1, 10'd100, 10'd50, 10'd0, 1'b1, 16'h0000);
        pix("oldpos2", 1'b1, 10'd200, 10'd50, 10'd0, 1'b0, 16'h0);
        frame(10'd200, 10'd50);
        pix("newpos", 1'b1, 10'd201, 10'd52, 10'd61, 1'b1, 16'h003D);
        pix("newmiss", 1'b1, 10'd100, 10'd50, 10'd0, 1'b0, 16'h0);

        // Wing animation: toggle after every 8 frame_start pulses
        flap_en = 1'b1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            frame(10'd200, 10'd50);
            if (k == 7 || k == 8 || k == 15 || k == 16)
                chk($sformatf("flap%0d", k), 16'(rom_sel), 16'((k / 8) % 2));
        end
        for (int k = 1; k <= 8; k++)
            frame(10'd200, 10'd50);
        chk("flap24", 16'(rom_sel), 16'h1);
        pix("sel1data", 1'b1, 10'd202, 10'd50, 10'd2, 1'b1, 16'h0402);
        frame(10'd200, 10'd50);
        flap_en = 1'b0;
        tick();
        chk("flapoff.sel", 16'(rom_sel), 16'h0);
        chk("flapoff.cnt", 16'(dut.cnt), 16'h0);

        // Bottom-right screen corner: box must not wrap
        frame(10'd1000, 10'd1000);
        pix("corner", 1'b1, 10'd1023, 10'd1023, 10'd713, 1'b1, 16'h02C9);
        pix("cornermiss", 1'b1, 10'd999, 10'd1000, 10'd0, 1'b0, 16'h0);
        pix("wrapmiss", 1'b1, 10'd3, 10'd1010, 10'd0, 1'b0, 16'h0);

        // Reset during streaming flushes the pipeline
        pix_valid = 1'b1; pix_x = 10'd1010; pix_y = 10'd1010;
        tick(); tick(); tick();
        rsta = 1'b0;
        tick();
        chk("midrst.addr", 16'(rom_addr), 16'h0);
        chk("midrst.valid", 16'(out_valid), 16'h0);
        chk("midrst.hit", 16'(out_hit), 16'h0);
        chk("midrst.rgb", out_rgb, 16'h0);
        tick();
        rsta = 1'b1;
        pix_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("postrst%0d", k), 16'(out_valid), 16'h0);
        end

        // Position registers cleared by reset
        pix("rstpos0", 1'b1, 10'd0, 10'd0, 10'd0, 1'b1, 16'h0000);
        pix("rstpos1", 1'b1, 10'd29, 10'd1, 10'd59, 1'b1, 16'h003B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
